// File: rtl/audio_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : audio_uart_rx
// Brief    : UART 8N1 receiver with sync-byte frame assembler feeding a
//            ping-pong sample buffer with a registered read port.
// Options  : AUDIO_RX_CHECKSUM_EN - frames carry a trailing 8-bit modular sum
//            of the samples; the bank swaps only when that sum matches.
// Revision : 1.0 - initial release
// ============================================================================
module audio_uart_rx #(
`ifdef SIM
   parameter int         CLK_HZ     = 10000000,
`else
   parameter int         CLK_HZ     = 120000000,
`endif
   parameter int         BAUD       = 921600,
   parameter int         OVERSAMPLE = 16,
   parameter int         BUF_SIZE   = 32,
   parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        rx,
   input  logic [$clog2(BUF_SIZE)-1:0] rd_addr,
   output logic signed [7:0]           rd_data,
   output logic                        byte_valid,
   output logic [7:0]                  byte_data,
   output logic                        frame_ready,
   output logic                        rd_bank,
   output logic [7:0]                  frame_count,
   output logic [7:0]                  err_count
);

   // Baud divider reload; a too-slow clock degenerates to one tick per clk.
   localparam int C_DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE) - 1;
   localparam int C_DIV     = (C_DIV_RAW < 0) ? 0 : C_DIV_RAW;
   localparam int C_DIV_W   = $clog2(C_DIV + 2);
   localparam int C_OS_W    = $clog2(OVERSAMPLE);
   localparam int C_AW      = $clog2(BUF_SIZE);

   localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(C_DIV);
   localparam logic [C_OS_W-1:0]  C_OS_HALF  = C_OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [C_OS_W-1:0]  C_OS_FULL  = C_OS_W'(OVERSAMPLE - 1);
   localparam logic [C_AW-1:0]    C_PTR_LAST = C_AW'(BUF_SIZE - 1);

   // Receiver states
   localparam logic [2:0] C_RX_IDLE  = 3'd0;
   localparam logic [2:0] C_RX_START = 3'd1;
   localparam logic [2:0] C_RX_DATA  = 3'd2;
   localparam logic [2:0] C_RX_STOP  = 3'd3;
   localparam logic [2:0] C_RX_BREAK = 3'd4;

   // Frame assembler states
   localparam logic [1:0] C_FR_HUNT  = 2'd0;
   localparam logic [1:0] C_FR_FILL  = 2'd1;
`ifdef AUDIO_RX_CHECKSUM_EN
   localparam logic [1:0] C_FR_CHECK = 2'd2;
`endif

   // Registered state
   logic [2:0]         sync_q, sync_d;          // [1] synchronized, [2] previous
   logic [C_DIV_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]         rx_state_q, rx_state_d;
   logic [C_OS_W-1:0]  os_cnt_q, os_cnt_d;
   logic [2:0]         bit_cnt_q, bit_cnt_d;
   logic [7:0]         shift_q, shift_d;
   logic               byte_valid_q, byte_valid_d;
   logic [7:0]         byte_data_q, byte_data_d;
   logic [7:0]         err_count_q, err_count_d;
   logic [1:0]         fr_state_q, fr_state_d;
   logic [C_AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic               rd_bank_q, rd_bank_d;
   logic               frame_ready_q, frame_ready_d;
   logic [7:0]         frame_count_q, frame_count_d;
   logic               have_frame_q, have_frame_d;
   logic [7:0]         rd_data_q, rd_data_d;
`ifdef AUDIO_RX_CHECKSUM_EN
   logic [7:0]         sum_q, sum_d;
`endif

   // Combinational strobes
   logic               w_rx;
   logic               w_fall;
   logic               w_restart;
   logic               w_tick;
   logic               w_frame_err;
   logic               w_cks_err;
   logic               w_we;
   logic [C_AW:0]      w_waddr;

   logic [7:0]         sample_mem [2*BUF_SIZE];

   assign w_rx      = sync_q[1];
   assign w_fall    = sync_q[2] & ~sync_q[1];
   assign w_restart = (rx_state_q == C_RX_IDLE) && w_fall;

   // Shift the raw line into the synchronizer; the third stage gives edge history.
   always_comb begin
      sync_d = {sync_q[1:0], rx};
   end

   // Oversampling tick generator, realigned to each detected start edge.
   always_comb begin
      baud_cnt_d = baud_cnt_q;
      w_tick     = 1'b0;
      if (w_restart) begin
         baud_cnt_d = '0;
      end else if (baud_cnt_q == C_DIV_LAST) begin
         baud_cnt_d = '0;
         w_tick     = 1'b1;
      end else begin
         baud_cnt_d = baud_cnt_q + 1'b1;
      end
   end

   // Bit-level receiver: start validation, LSB-first data, stop check, break wait.
   always_comb begin
      rx_state_d   = rx_state_q;
      os_cnt_d     = os_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      byte_valid_d = 1'b0;
      byte_data_d  = byte_data_q;
      w_frame_err  = 1'b0;
      case (rx_state_q)
         C_RX_IDLE: begin
            if (w_restart) begin
               rx_state_d = C_RX_START;
               os_cnt_d   = '0;
            end
         end
         C_RX_START: begin
            if (w_tick) begin
               if (os_cnt_q == C_OS_HALF) begin
                  os_cnt_d   = '0;
                  bit_cnt_d  = '0;
                  // A line already back high is a glitch, not a start bit.
                  rx_state_d = w_rx ? C_RX_IDLE : C_RX_DATA;
               end else begin
                  os_cnt_d = os_cnt_q + 1'b1;
               end
            end
         end
         C_RX_DATA: begin
            if (w_tick) begin
               if (os_cnt_q == C_OS_FULL) begin
                  os_cnt_d  = '0;
                  shift_d   = {w_rx, shift_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 3'd7) begin
                     rx_state_d = C_RX_STOP;
                  end
               end else begin
                  os_cnt_d = os_cnt_q + 1'b1;
               end
            end
         end
         C_RX_STOP: begin
            if (w_tick) begin
               if (os_cnt_q == C_OS_FULL) begin
                  os_cnt_d = '0;
                  if (w_rx) begin
                     byte_valid_d = 1'b1;
                     byte_data_d  = shift_q;
                     rx_state_d   = C_RX_IDLE;
                  end else begin
                     w_frame_err = 1'b1;
                     rx_state_d  = C_RX_BREAK;
                  end
               end else begin
                  os_cnt_d = os_cnt_q + 1'b1;
               end
            end
         end
         C_RX_BREAK: begin
            // Any low sample restarts the one-bit-time high qualification.
            if (!w_rx) begin
               os_cnt_d = '0;
            end else if (w_tick) begin
               if (os_cnt_q == C_OS_FULL) begin
                  os_cnt_d   = '0;
                  rx_state_d = C_RX_IDLE;
               end else begin
                  os_cnt_d = os_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            rx_state_d = C_RX_IDLE;
            os_cnt_d   = '0;
         end
      endcase
   end

   // Frame assembler: hunt for sync, fill the hidden bank, swap when complete.
   always_comb begin
      fr_state_d    = fr_state_q;
      wr_ptr_d      = wr_ptr_q;
      rd_bank_d     = rd_bank_q;
      frame_ready_d = 1'b0;
      frame_count_d = frame_count_q;
      have_frame_d  = have_frame_q;
      w_we          = 1'b0;
      w_cks_err     = 1'b0;
      w_waddr       = {~rd_bank_q, wr_ptr_q};
`ifdef AUDIO_RX_CHECKSUM_EN
      sum_d         = sum_q;
`endif
      case (fr_state_q)
         C_FR_HUNT: begin
            if (byte_valid_d && (shift_q == SYNC_BYTE)) begin
               fr_state_d = C_FR_FILL;
               wr_ptr_d   = '0;
`ifdef AUDIO_RX_CHECKSUM_EN
               sum_d      = '0;
`endif
            end
         end
         C_FR_FILL: begin
            if (w_frame_err) begin
               fr_state_d = C_FR_HUNT;
            end else if (byte_valid_d) begin
               w_we     = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
`ifdef AUDIO_RX_CHECKSUM_EN
               sum_d    = sum_q + shift_q;
               if (wr_ptr_q == C_PTR_LAST) begin
                  fr_state_d = C_FR_CHECK;
               end
`else
               if (wr_ptr_q == C_PTR_LAST) begin
                  fr_state_d    = C_FR_HUNT;
                  rd_bank_d     = ~rd_bank_q;
                  frame_ready_d = 1'b1;
                  frame_count_d = frame_count_q + 8'd1;
                  have_frame_d  = 1'b1;
               end
`endif
            end
         end
`ifdef AUDIO_RX_CHECKSUM_EN
         C_FR_CHECK: begin
            if (w_frame_err) begin
               fr_state_d = C_FR_HUNT;
            end else if (byte_valid_d) begin
               fr_state_d = C_FR_HUNT;
               if (shift_q == sum_q) begin
                  rd_bank_d     = ~rd_bank_q;
                  frame_ready_d = 1'b1;
                  frame_count_d = frame_count_q + 8'd1;
                  have_frame_d  = 1'b1;
               end else begin
                  w_cks_err = 1'b1;
               end
            end
         end
`endif
         default: begin
            fr_state_d = C_FR_HUNT;
         end
      endcase
   end

   // Error counter saturates so a noisy line cannot wrap it back to zero.
   always_comb begin
      err_count_d = err_count_q;
      if ((w_frame_err || w_cks_err) && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   // Read the visible bank; nothing valid is readable before the first swap.
   always_comb begin
      rd_data_d = have_frame_q ? sample_mem[{rd_bank_q, rd_addr}] : 8'h00;
   end

   // Sample storage write port, kept reset-free so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (w_we) begin
         sample_mem[w_waddr] <= shift_q;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q        <= 3'b111;
         baud_cnt_q    <= '0;
         rx_state_q    <= C_RX_IDLE;
         os_cnt_q      <= '0;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         byte_valid_q  <= 1'b0;
         byte_data_q   <= '0;
         err_count_q   <= '0;
         fr_state_q    <= C_FR_HUNT;
         wr_ptr_q      <= '0;
         rd_bank_q     <= 1'b0;
         frame_ready_q <= 1'b0;
         frame_count_q <= '0;
         have_frame_q  <= 1'b0;
         rd_data_q     <= '0;
`ifdef AUDIO_RX_CHECKSUM_EN
         sum_q         <= '0;
`endif
      end else begin
         sync_q        <= sync_d;
         baud_cnt_q    <= baud_cnt_d;
         rx_state_q    <= rx_state_d;
         os_cnt_q      <= os_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         byte_valid_q  <= byte_valid_d;
         byte_data_q   <= byte_data_d;
         err_count_q   <= err_count_d;
         fr_state_q    <= fr_state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_bank_q     <= rd_bank_d;
         frame_ready_q <= frame_ready_d;
         frame_count_q <= frame_count_d;
         have_frame_q  <= have_frame_d;
         rd_data_q     <= rd_data_d;
`ifdef AUDIO_RX_CHECKSUM_EN
         sum_q         <= sum_d;
`endif
      end
   end

   assign rd_data     = rd_data_q;
   assign byte_valid  = byte_valid_q;
   assign byte_data   = byte_data_q;
   assign frame_ready = frame_ready_q;
   assign rd_bank     = rd_bank_q;
   assign frame_count = frame_count_q;
   assign err_count   = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_uart_rx
// Brief    : Self-checking bench for audio_uart_rx with a frame-level model.
// Options  : AUDIO_RX_CHECKSUM_EN - adds checksum frames and scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_uart_rx;

   localparam int CLK_HZ     = 10000000;
   localparam int BAUD       = 625000;
   localparam int OVERSAMPLE = 16;
   localparam int BUF_SIZE   = 32;
   localparam int BIT_CLKS   = CLK_HZ / BAUD;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              rx  = 1'b1;
   logic [4:0]        rd_addr = '0;
   logic signed [7:0] rd_data;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              frame_ready;
   logic              rd_bank;
   logic [7:0]        frame_count;
   logic [7:0]        err_count;

   audio_uart_rx #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OVERSAMPLE),
      .BUF_SIZE   (BUF_SIZE),
      .SYNC_BYTE  (8'hA5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx          (rx),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .byte_valid  (byte_valid),
      .byte_data   (byte_data),
      .frame_ready (frame_ready),
      .rd_bank     (rd_bank),
      .frame_count (frame_count),
      .err_count   (err_count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- frame-level reference model ----------------
   // m_pos: -1 while hunting for sync, 0..BUF_SIZE-1 next sample slot,
   // BUF_SIZE while waiting for the checksum byte.
   logic [7:0] m_buf [2][BUF_SIZE];
   int         m_pos, m_bank, m_frames, m_errs;
   bit         m_have;
   logic [7:0] m_sum, m_last;
   logic [8:0] exp_q [$];            // {good_stop, data} in transmit order
   int         n_ready, n_bytes;
   logic [7:0] fbuf [BUF_SIZE];

   function automatic int sat_inc(input int v);
      return (v >= 255) ? 255 : v + 1;
   endfunction

   task automatic model_reset();
      m_pos = -1; m_bank = 0; m_frames = 0; m_errs = 0; m_have = 0;
      m_sum = 0; m_last = 0; n_ready = 0; n_bytes = 0;
      exp_q.delete();
   endtask

   task automatic model_swap();
      m_bank   = 1 - m_bank;
      m_frames = (m_frames + 1) % 256;
      m_have   = 1;
      m_pos    = -1;
   endtask

   task automatic model_byte(input logic [7:0] b, output bit ready);
      ready  = 0;
      m_last = b;
      if (m_pos < 0) begin
         if (b == 8'hA5) begin
            m_pos = 0;
            m_sum = 0;
         end
      end else if (m_pos < BUF_SIZE) begin
         m_buf[1-m_bank][m_pos] = b;
         m_sum = m_sum + b;
         m_pos++;
`ifndef AUDIO_RX_CHECKSUM_EN
         if (m_pos == BUF_SIZE) begin
            model_swap();
            ready = 1;
         end
`endif
      end else begin
         if (b == m_sum) begin
            model_swap();
            ready = 1;
         end else begin
            m_errs = sat_inc(m_errs);
            m_pos  = -1;
         end
      end
   endtask

   // Cycle-by-cycle comparison of DUT outputs against the model.
   initial begin : compare
      logic [8:0] e;
      bit         rdy;
      int         exp_err;
      forever begin
         @(negedge clk);
         if (rst) begin
            model_reset();
         end else if (byte_valid === 1'b1) begin
            n_bytes++;
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL byte_unexpected: got byte 0x%02h, expected no byte", byte_data);
            end else begin
               e = exp_q.pop_front();
               check("byte_rx", {23'd0, 1'b1, byte_data}, {23'd0, e});
               model_byte(e[7:0], rdy);
               if (frame_ready) n_ready++;
               check("frame_ready_on_byte", {31'd0, frame_ready}, {31'd0, rdy});
               check("state_on_byte", {15'd0, rd_bank, frame_count, err_count},
                     {15'd0, m_bank[0], 8'(m_frames), 8'(m_errs)});
            end
         end else if (err_count !== 8'(m_errs)) begin
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL err_unexpected: got err_count %0d, expected %0d", err_count, m_errs);
            end else begin
               e = exp_q.pop_front();
               exp_err = e[8] ? m_errs : sat_inc(m_errs);
               check("framing_err_count", {24'd0, err_count}, 32'(exp_err));
               if (!e[8]) begin
                  m_errs = exp_err;
                  m_pos  = -1;
               end
            end
         end else begin
            if (frame_ready) n_ready++;
            check("idle_outputs", {7'd0, frame_ready, rd_bank, byte_data, frame_count, err_count},
                  {7'd0, 1'b0, m_bank[0], m_last, 8'(m_frames), 8'(m_errs)});
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic v);
      rx = v;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit good);
      exp_q.push_back({good, b});
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(good);
      if (!good) begin
         rx = 1'b1;
         idle(30);
      end
   endtask

   task automatic send_samples();
      for (int i = 0; i < BUF_SIZE; i++) send_byte(fbuf[i], 1'b1);
   endtask

   task automatic send_frame();
      logic [7:0] s;
      s = 8'h00;
      send_byte(8'hA5, 1'b1);
      send_samples();
      for (int i = 0; i < BUF_SIZE; i++) s = s + fbuf[i];
`ifdef AUDIO_RX_CHECKSUM_EN
      send_byte(s, 1'b1);
`endif
      idle(20);
   endtask

   task automatic rd_check(input int addr, input logic [7:0] lit);
      logic [7:0] mexp;
      @(negedge clk);
      rd_addr = addr[4:0];
      @(negedge clk);
      mexp = m_have ? m_buf[m_bank][addr] : 8'h00;
      check($sformatf("rd_model[%0d]", addr), {24'd0, $unsigned(rd_data)}, {24'd0, mexp});
      check($sformatf("rd_literal[%0d]", addr), {24'd0, $unsigned(rd_data)}, {24'd0, lit});
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_pulses"}, {30'd0, byte_valid, frame_ready}, 32'd0);
      check({tag, "_bank_bytedata"}, {23'd0, rd_bank, byte_data}, 32'd0);
      check({tag, "_counts"}, {16'd0, frame_count, err_count}, 32'd0);
      check({tag, "_rd_data"}, {24'd0, $unsigned(rd_data)}, 32'd0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      check_zero("in_reset");
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check_zero("after_reset");
   endtask

   // ---------------- directed scenarios ----------------
   initial begin : main
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check_zero("reset");
      rd_check(3, 8'h00);

      // Frame A: ramp samples
      for (int i = 0; i < BUF_SIZE; i++) fbuf[i] = 8'(i);
      send_frame();
      check("A_frame_count", {24'd0, frame_count}, 32'd1);
      check("A_rd_bank", {31'd0, rd_bank}, 32'd1);
      check("A_ready_pulses", 32'(n_ready), 32'd1);
      rd_check(5, 8'h05);
      rd_check(31, 8'h1F);

      // Junk bytes ahead of sync are ignored
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      for (int i = 0; i < BUF_SIZE; i++) fbuf[i] = 8'h80;
      send_frame();
      check("B_frame_count", {24'd0, frame_count}, 32'd2);
      check("B_ready_pulses", 32'(n_ready), 32'd2);
      check("B_rd_bank", {31'd0, rd_bank}, 32'd0);
      rd_check(0, 8'h80);
      rd_check(17, 8'h80);
      rd_check(31, 8'h80);
      check("B_signed", ($signed(rd_data) == -8'sd128) ? 32'd1 : 32'd0, 32'd1);

      // Framing error aborts a partial frame
      do_reset();
      send_byte(8'hA5, 1'b1);
      for (int i = 0; i < 10; i++) send_byte(8'h40 + 8'(i), 1'b1);
      send_byte(8'h55, 1'b0);
      idle(10);
      check("C_err_count", {24'd0, err_count}, 32'd1);
      check("C_no_swap", {23'd0, rd_bank, frame_count}, 32'd0);
      check("C_no_ready", 32'(n_ready), 32'd0);
      for (int i = 0; i < BUF_SIZE; i++) fbuf[i] = 8'hF0 - 8'(i);
      send_frame();
      check("C_frame_count", {24'd0, frame_count}, 32'd1);
      check("C_rd_bank", {31'd0, rd_bank}, 32'd1);
      rd_check(0, 8'hF0);
      rd_check(9, 8'hE7);

      // False start glitch
      do_reset();
      rx = 1'b0;
      idle(2);
      rx = 1'b1;
      idle(60);
      check("D_no_byte", 32'(n_bytes), 32'd0);
      check("D_err_count", {24'd0, err_count}, 32'd0);

      // Sync value inside data, then reset mid-frame
      for (int i = 0; i < BUF_SIZE; i++) fbuf[i] = 8'hA5;
      send_frame();
      check("E_ready_pulses", 32'(n_ready), 32'd1);
      check("E_frame_count", {24'd0, frame_count}, 32'd1);
      rd_check(12, 8'hA5);
      send_byte(8'hA5, 1'b1);
      for (int i = 0; i < 12; i++) send_byte(8'h11, 1'b1);
      do_reset();
      rd_check(12, 8'h00);
      for (int i = 0; i < BUF_SIZE; i++) fbuf[i] = 8'(i * 7);
      send_frame();
      check("E_frame_count_after", {24'd0, frame_count}, 32'd1);
      check("E_rd_bank_after", {31'd0, rd_bank}, 32'd1);
      rd_check(2, 8'h0E);
      rd_check(31, 8'hD9);

`ifdef AUDIO_RX_CHECKSUM_EN
      // Checksum good then bad
      do_reset();
      for (int i = 0; i < BUF_SIZE; i++) fbuf[i] = 8'h01;
      send_byte(8'hA5, 1'b1);
      send_samples();
      send_byte(8'h20, 1'b1);
      idle(20);
      check("F_good_frames", {24'd0, frame_count}, 32'd1);
      check("F_good_bank", {31'd0, rd_bank}, 32'd1);
      send_byte(8'hA5, 1'b1);
      send_samples();
      send_byte(8'h21, 1'b1);
      idle(20);
      check("F_bad_err", {24'd0, err_count}, 32'd1);
      check("F_bad_frames", {24'd0, frame_count}, 32'd1);
      check("F_bad_bank", {31'd0, rd_bank}, 32'd1);
      check("F_ready_pulses", 32'(n_ready), 32'd1);
`endif

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #(10 * 95000);
      $display("FAIL watchdog: got no finish, expected finish within 95000 cycles");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
